matrix_result_display_seq: RTL and testbench
============================================

// Module: matrix_result_display_seq
// PURPOSE
//  Parametrised successor of the fixed 2x2 result display. Snapshots two DIMxDIM result matrices
//  (systolic array and custom datapath) on a load pulse and walks all 2*DIM*DIM elements in order:
//  all SA elements, then all custom elements. Advance is automatic (dwell timer) or manual (step edge).
//  Each element is shown on a 4-digit multiplexed 7-segment display driven directly by this block.
// PARAMETERS
//  DIM      2            matrix dimension, 1..4
//  DW       8            element width in bits, 1..8, zero-extended to 8 for display
//  DWELL    100_000_000  clk cycles per element in auto mode, >=2
//  REFRESH  100_000      clk cycles per digit in the scan, >=1
// PORTS
//  clk             in   1             system clock
//  rst             in   1             synchronous active-high reset
//  in_sa           in   DIM*DIM*DW    SA matrix, row-major, element k = [k*DW +: DW]
//  in_custom       in   DIM*DIM*DW    custom matrix, same packing
//  load            in   1             1-cycle pulse: capture both matrices, restart at element 0
//  display_en      in   1             0 = blank and freeze; 1 = run
//  mode_auto       in   1             1 = dwell-timer advance; 0 = advance on step rising edge
//  step            in   1             synchronous level; 0->1 transition advances one element
//  anode_activate  out  4             active-low one-hot digit enable
//  led_out         out  7             active-low segments {a,b,c,d,e,f,g}
//  cur_idx         out  $clog2(2*DIM*DIM)  sequence index shown; bit MSB-side selects source
//  cur_src         out  1             0 = SA, 1 = custom
//  valid           out  1             1 once a snapshot has been loaded
// BEHAVIOUR
//  Reset: state IDLE; snapshots, cur_idx, cur_src, valid, dwell/refresh/digit counters = 0;
//   anode_activate = 4'b1111; led_out = 7'b1111111; step edge register = 0.
//  FSM: IDLE  -> SHOW on load.
//       SHOW  -> SHOW on load: recapture, cur_idx = 0, dwell = 0. No other exit except rst.
//  Index: idx in 0..2*DIM*DIM-1. cur_src = (idx >= DIM*DIM). Element = idx mod DIM*DIM.
//   Advance: idx == 2*DIM*DIM-1 wraps to 0, else idx+1.
//   Auto: dwell counts 0..DWELL-1. Advance on the cycle dwell == DWELL-1; dwell then returns to 0.
//   Manual: advance once per 0->1 of step. Held high = one advance. Dwell is held at 0.
//   mode_auto change: dwell resets to 0. No advance on the switching cycle.
//   load and step/dwell expiry in the same cycle: load wins, idx = 0.
//  display_en = 0: anodes 4'b1111, segments 7'b1111111. Dwell, refresh and idx frozen.
//   Snapshots and load still operate. On re-enable, scanning resumes from the frozen digit.
//  IDLE: outputs stay blank regardless of display_en.
//  Scan: refresh counts 0..REFRESH-1. On wrap, digit = digit+1 mod 4.
//   anode_activate = ~(4'b0001 << digit).
//   anode and led_out are registered and update in the same cycle, 1 clk after digit/idx changes.
//  Digit content (hex mode):
//   d3 = source glyph: '5' (0100100) for SA, 'C' (0110001) for custom.
//   d2 = element index hex. d1 = value[7:4] hex. d0 = value[3:0] hex.
//  Segment table: 0=0000001 1=1001111 2=0010010 3=0000110 4=1001100 5=0100100 6=0100000 7=0001111
//   8=0000000 9=0000100 A=0001000 b=1100000 C=0110001 d=1000010 E=0110000 F=0111000
// CONFIGURATION
//  DISPLAY_BCD_EN defined:
//   value is converted to 3 decimal digits (binary-to-BCD, combinational or pipelined; total
//   display latency stays 1 clk after idx change). d2 = hundreds, d1 = tens, d0 = ones,
//   with leading zeros. d3 = source glyph. Element index is not shown.
//  DISPLAY_BCD_EN undefined: hex mode as above. No BCD logic is synthesised.
// TESTING  (DIM=2, DW=8, DWELL=4, REFRESH=2)
//  1. rst high 2 clk -> anode 1111, led 1111111, cur_idx 0, valid 0; stays blank with display_en=1 and no load.
//  2. in_sa elem0=8'h3A, load, mode_auto=0 -> valid=1; scan shows d3=0100100, d2=0000001, d1=0000110, d0=0001000.
//  3. mode_auto=1 -> idx steps 0..7 every 4 clk, cur_src=1 and d3=0110001 for idx 4..7; after 7 wraps to 0.
//  4. mode_auto=0, step held high 10 clk then low -> exactly one advance; 3 separate pulses -> +3.
//  5. idx=5, load and step in same cycle -> idx=0, new snapshot shown; display_en=0 mid-run -> blank, idx frozen 8 clk.
//  6. DISPLAY_BCD_EN, elem0=8'hFF -> d2=0010010 ('2'), d1=0100100 ('5'), d0=0100100 ('5'); 8'h07 -> 0,0,7.

Source files
------------

// File: rtl/matrix_result_display_seq.sv
// matrix_result_display_seq: snapshots two DIMxDIM result matrices (SA, custom)
// and walks all 2*DIM*DIM elements on a 4-digit multiplexed 7-seg display.
// Ports: clk, rst (sync, active high); in_sa/in_custom row-major DW-bit elements;
//  load (capture + restart), display_en (0 blanks and freezes), mode_auto
//  (1 = dwell timer, 0 = step rising edge), step; anode_activate/led_out
//  (active low, registered); cur_idx, cur_src (0 = SA), valid (snapshot held).
// Build option: define DISPLAY_BCD_EN to show values as 3 decimal digits
//  instead of element index + hex byte.
module matrix_result_display_seq #(
  parameter int DIM     = 2,
  parameter int DW      = 8,
  parameter int DWELL   = 100_000_000,
  parameter int REFRESH = 100_000,
  localparam int N      = DIM * DIM,
  localparam int TOT    = 2 * N,
  localparam int IW     = $clog2(TOT)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N*DW-1:0] in_sa,
  input  logic [N*DW-1:0] in_custom,
  input  logic            load,
  input  logic            display_en,
  input  logic            mode_auto,
  input  logic            step,
  output logic [3:0]      anode_activate,
  output logic [6:0]      led_out,
  output logic [IW-1:0]   cur_idx,
  output logic            cur_src,
  output logic            valid
);

  localparam int DWW = $clog2(DWELL);
  localparam int RW  = (REFRESH > 1) ? $clog2(REFRESH) : 1;

  localparam logic [DWW-1:0] DWELL_LAST = DWW'(DWELL - 1);
  localparam logic [RW-1:0]  RF_LAST    = RW'(REFRESH - 1);
  localparam logic [IW-1:0]  IDX_LAST   = IW'(TOT - 1);
  localparam logic [IW-1:0]  N_IW       = IW'(N);

  localparam logic [6:0] GLYPH_SA = 7'b0100100;
  localparam logic [6:0] GLYPH_CU = 7'b0110001;
  localparam logic [3:0] AN_OFF   = 4'b1111;
  localparam logic [6:0] SEG_OFF  = 7'b1111111;

  typedef enum logic {
    IDLE,
    SHOW
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [N*DW-1:0] snap_sa;
  logic [N*DW-1:0] snap_cu;
  logic [IW-1:0]   idx_q;
  logic [IW-1:0]   idx_nxt;
  logic [DWW-1:0]  dwell_q;
  logic [RW-1:0]   refresh_q;
  logic [1:0]      digit_q;
  logic            step_q;
  logic            mode_q;
  logic            run;
  logic            step_rise;
  logic            mode_chg;
  logic            src;
  logic [IW-1:0]   elem;
  logic [DW-1:0]   raw;
  logic [7:0]      value;
  logic [3:0]      anode_d;
  logic [6:0]      led_d;

  function automatic logic [6:0] hex_seg(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0:    s = 7'b0000001;
      4'h1:    s = 7'b1001111;
      4'h2:    s = 7'b0010010;
      4'h3:    s = 7'b0000110;
      4'h4:    s = 7'b1001100;
      4'h5:    s = 7'b0100100;
      4'h6:    s = 7'b0100000;
      4'h7:    s = 7'b0001111;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0000100;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b1100000;
      4'hC:    s = 7'b0110001;
      4'hD:    s = 7'b1000010;
      4'hE:    s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return s;
  endfunction

`ifdef DISPLAY_BCD_EN
  // Double dabble: {hundreds, tens, ones}.
  function automatic logic [11:0] bin2bcd(input logic [7:0] b);
    logic [11:0] r;
    r = '0;
    for (int i = 7; i >= 0; i--) begin
      if (r[3:0] >= 4'd5)  r[3:0]  = r[3:0] + 4'd3;
      if (r[7:4] >= 4'd5)  r[7:4]  = r[7:4] + 4'd3;
      if (r[11:8] >= 4'd5) r[11:8] = r[11:8] + 4'd3;
      r = {r[10:0], b[i]};
    end
    return r;
  endfunction

  logic [11:0] bcd;
  assign bcd = bin2bcd(value);
`endif

  assign run       = (state_q == SHOW) && display_en;
  assign step_rise = step & ~step_q;
  assign mode_chg  = mode_auto ^ mode_q;
  assign idx_nxt   = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);

  assign src  = (idx_q >= N_IW);
  assign elem = src ? idx_q - N_IW : idx_q;

  always_comb begin
    raw = '0;
    for (int k = 0; k < N; k++) begin
      if (elem == IW'(k)) begin
        raw = src ? snap_cu[k*DW +: DW] : snap_sa[k*DW +: DW];
      end
    end
  end

  assign value = 8'(raw);

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (load) state_d = SHOW;
      default: state_d = SHOW;
    endcase
  end

  // Snapshot, sequence index and dwell timer.
  // A mode switch only restarts the dwell; it never advances by itself.
  always_ff @(posedge clk) begin
    if (rst) begin
      snap_sa <= '0;
      snap_cu <= '0;
      idx_q   <= '0;
      dwell_q <= '0;
      valid   <= 1'b0;
      step_q  <= 1'b0;
      mode_q  <= 1'b0;
    end else begin
      step_q <= step;
      mode_q <= mode_auto;
      if (load) begin
        snap_sa <= in_sa;
        snap_cu <= in_custom;
        idx_q   <= '0;
        dwell_q <= '0;
        valid   <= 1'b1;
      end else if (run) begin
        if (mode_chg) begin
          dwell_q <= '0;
        end else if (mode_auto) begin
          if (dwell_q == DWELL_LAST) begin
            dwell_q <= '0;
            idx_q   <= idx_nxt;
          end else begin
            dwell_q <= dwell_q + DWW'(1);
          end
        end else begin
          dwell_q <= '0;
          if (step_rise) idx_q <= idx_nxt;
        end
      end
    end
  end

  // Digit scan; frozen while blanked so it resumes on the same digit.
  always_ff @(posedge clk) begin
    if (rst) begin
      refresh_q <= '0;
      digit_q   <= '0;
    end else if (run) begin
      if (refresh_q == RF_LAST) begin
        refresh_q <= '0;
        digit_q   <= digit_q + 2'd1;
      end else begin
        refresh_q <= refresh_q + RW'(1);
      end
    end
  end

  // FSM: outputs (next value of the registered display)
  always_comb begin
    anode_d = ~(4'b0001 << digit_q);
    led_d   = SEG_OFF;
    unique case (digit_q)
      2'd3: led_d = src ? GLYPH_CU : GLYPH_SA;
`ifdef DISPLAY_BCD_EN
      2'd2: led_d = hex_seg(bcd[11:8]);
      2'd1: led_d = hex_seg(bcd[7:4]);
      2'd0: led_d = hex_seg(bcd[3:0]);
`else
      2'd2: led_d = hex_seg(4'(elem));
      2'd1: led_d = hex_seg(value[7:4]);
      2'd0: led_d = hex_seg(value[3:0]);
`endif
    endcase
    if (!run) begin
      anode_d = AN_OFF;
      led_d   = SEG_OFF;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      anode_activate <= AN_OFF;
      led_out        <= SEG_OFF;
    end else begin
      anode_activate <= anode_d;
      led_out        <= led_d;
    end
  end

  assign cur_idx = idx_q;
  assign cur_src = src;

endmodule

// File: tb/tb_matrix_result_display_seq.sv
// Bench for matrix_result_display_seq (DIM=2, DW=8, DWELL=4, REFRESH=2):
// table vectors, hand sequences and random stimulus against a reference model.
module tb_matrix_result_display_seq;

  localparam int DWELL   = 4;
  localparam int REFRESH = 2;
  localparam int NE      = 4;
  localparam int TOT     = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] in_sa = '0;
  logic [31:0] in_custom = '0;
  logic        load = 1'b0;
  logic        display_en = 1'b0;
  logic        mode_auto = 1'b0;
  logic        step = 1'b0;
  logic [3:0]  anode_activate;
  logic [6:0]  led_out;
  logic [2:0]  cur_idx;
  logic        cur_src;
  logic        valid;

  always #5 clk = ~clk;

  matrix_result_display_seq #(
    .DIM(2), .DW(8), .DWELL(DWELL), .REFRESH(REFRESH)
  ) dut (
    .clk(clk), .rst(rst),
    .in_sa(in_sa), .in_custom(in_custom),
    .load(load), .display_en(display_en),
    .mode_auto(mode_auto), .step(step),
    .anode_activate(anode_activate), .led_out(led_out),
    .cur_idx(cur_idx), .cur_src(cur_src), .valid(valid)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
  endtask

  logic [6:0] seg_tab [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  // Reference model: digit follows the count of lit cycles, idx follows
  // a dwell tick count or step edges.
  bit         m_show, m_valid, m_pstep, m_pmode;
  int         m_idx, m_timer, m_scan;
  logic [7:0] m_sa [NE];
  logic [7:0] m_cu [NE];
  logic [3:0] m_an  = 4'hF;
  logic [6:0] m_led = 7'h7F;

  function automatic void render(input int dig, input int idx,
                                 output logic [3:0] an,
                                 output logic [6:0] ld);
    int e, v;
    bit s;
    s  = (idx >= NE);
    e  = idx % NE;
    v  = s ? int'(m_cu[e]) : int'(m_sa[e]);
    an = 4'hF;
    an[dig] = 1'b0;
    case (dig)
      3: ld = s ? 7'b0110001 : 7'b0100100;
`ifdef DISPLAY_BCD_EN
      2: ld = seg_tab[v / 100];
      1: ld = seg_tab[(v / 10) % 10];
      default: ld = seg_tab[v % 10];
`else
      2: ld = seg_tab[e];
      1: ld = seg_tab[v / 16];
      default: ld = seg_tab[v % 16];
`endif
    endcase
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_show = 0; m_valid = 0; m_pstep = 0; m_pmode = 0;
      m_idx = 0; m_timer = 0; m_scan = 0;
      for (int k = 0; k < NE; k++) begin
        m_sa[k] = '0;
        m_cu[k] = '0;
      end
      m_an = 4'hF; m_led = 7'h7F;
    end else begin
      if (m_show && display_en) begin
        render((m_scan / REFRESH) % 4, m_idx, m_an, m_led);
        m_scan++;
      end else begin
        m_an = 4'hF; m_led = 7'h7F;
      end
      if (load) begin
        for (int k = 0; k < NE; k++) begin
          m_sa[k] = in_sa[k*8 +: 8];
          m_cu[k] = in_custom[k*8 +: 8];
        end
        m_show = 1; m_valid = 1; m_idx = 0; m_timer = 0;
      end else if (m_show && display_en) begin
        if (mode_auto != m_pmode) m_timer = 0;
        else if (mode_auto) begin
          m_timer++;
          if (m_timer == DWELL) begin
            m_timer = 0;
            m_idx = (m_idx + 1) % TOT;
          end
        end else begin
          m_timer = 0;
          if (step && !m_pstep) m_idx = (m_idx + 1) % TOT;
        end
      end
      m_pstep = step;
      m_pmode = mode_auto;
    end
  end

  task automatic cmp_all();
    chk("idx", 32'(cur_idx), 32'(m_idx));
    chk("src", 32'(cur_src), 32'(m_idx >= NE));
    chk("valid", 32'(valid), 32'(m_valid));
    chk("anode", 32'(anode_activate), 32'(m_an));
    chk("led", 32'(led_out), 32'(m_led));
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    cmp_all();
  endtask

  task automatic pulse();
    step = 1'b1; tick();
    step = 1'b0; tick();
  endtask

  typedef struct {
    bit         src;
    logic [7:0] val;
    logic [6:0] e3, e2, e1, e0;
  } vec_t;

  vec_t vecs [4];

  task automatic run_vec(input vec_t v);
    logic [6:0] seen [4];
    logic [3:0] a;
    in_sa = $urandom;
    in_custom = $urandom;
    if (v.src) in_custom[7:0] = v.val;
    else       in_sa[7:0] = v.val;
    mode_auto = 1'b0;
    load = 1'b1; tick(); load = 1'b0;
    in_sa = $urandom; in_custom = $urandom;
    chk("vec_valid", 32'(valid), 32'd1);
    if (v.src) repeat (4) pulse();
    chk("vec_idx", 32'(cur_idx), v.src ? 32'd4 : 32'd0);
    for (int d = 0; d < 4; d++) seen[d] = 7'h7F;
    repeat (10) begin
      tick();
      for (int d = 0; d < 4; d++) begin
        a = 4'b0001 << d;
        if (anode_activate == ~a) seen[d] = led_out;
      end
    end
    chk("vec_d3", 32'(seen[3]), 32'(v.e3));
    chk("vec_d2", 32'(seen[2]), 32'(v.e2));
    chk("vec_d1", 32'(seen[1]), 32'(v.e1));
    chk("vec_d0", 32'(seen[0]), 32'(v.e0));
  endtask

  initial begin
    int s;
`ifdef DISPLAY_BCD_EN
    vecs[0] = '{1'b0, 8'hFF, 7'b0100100, 7'b0010010, 7'b0100100, 7'b0100100};
    vecs[1] = '{1'b0, 8'h07, 7'b0100100, 7'b0000001, 7'b0000001, 7'b0001111};
    vecs[2] = '{1'b1, 8'hC5, 7'b0110001, 7'b1001111, 7'b0000100, 7'b0001111};
    vecs[3] = '{1'b0, 8'h64, 7'b0100100, 7'b1001111, 7'b0000001, 7'b0000001};
`else
    vecs[0] = '{1'b0, 8'h3A, 7'b0100100, 7'b0000001, 7'b0000110, 7'b0001000};
    vecs[1] = '{1'b1, 8'hC5, 7'b0110001, 7'b0000001, 7'b0110001, 7'b0100100};
    vecs[2] = '{1'b0, 8'h0F, 7'b0100100, 7'b0000001, 7'b0000001, 7'b0111000};
    vecs[3] = '{1'b1, 8'hB7, 7'b0110001, 7'b0000001, 7'b1100000, 7'b0001111};
`endif

    rst = 1'b1;
    tick(); tick();
    chk("rst_anode", 32'(anode_activate), 32'hF);
    chk("rst_led", 32'(led_out), 32'h7F);
    chk("rst_idx", 32'(cur_idx), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    rst = 1'b0;
    display_en = 1'b1;
    repeat (6) begin
      tick();
      chk("idle_blank", 32'(anode_activate), 32'hF);
    end

    foreach (vecs[i]) run_vec(vecs[i]);

    load = 1'b1; tick(); load = 1'b0;
    chk("auto_start", 32'(cur_idx), 32'd0);
    mode_auto = 1'b1;
    tick();
    repeat (3) tick();
    chk("auto_hold", 32'(cur_idx), 32'd0);
    tick();
    chk("auto_first", 32'(cur_idx), 32'd1);
    for (int k = 2; k <= 8; k++) begin
      repeat (4) tick();
      chk("auto_walk", 32'(cur_idx), 32'(k % TOT));
      chk("auto_src", 32'(cur_src), 32'((k % TOT) >= NE));
    end

    mode_auto = 1'b0;
    tick();
    s = int'(cur_idx);
    step = 1'b1;
    repeat (10) tick();
    step = 1'b0;
    tick();
    chk("step_held", 32'(cur_idx), 32'((s + 1) % TOT));
    repeat (3) pulse();
    chk("step_three", 32'(cur_idx), 32'((s + 4) % TOT));

    load = 1'b1; tick(); load = 1'b0;
    repeat (5) pulse();
    chk("idx_five", 32'(cur_idx), 32'd5);
    in_sa = $urandom; in_custom = $urandom;
    load = 1'b1; step = 1'b1; tick();
    load = 1'b0; step = 1'b0;
    chk("load_wins", 32'(cur_idx), 32'd0);
    repeat (8) tick();
    repeat (2) pulse();
    mode_auto = 1'b1;
    tick(); tick();
    display_en = 1'b0;
    tick();
    s = int'(cur_idx);
    repeat (8) begin
      tick();
      chk("off_idx", 32'(cur_idx), 32'(s));
      chk("off_anode", 32'(anode_activate), 32'hF);
      chk("off_led", 32'(led_out), 32'h7F);
    end
    display_en = 1'b1;
    repeat (6) tick();

    repeat (400) begin
      load = ($urandom_range(0, 19) == 0);
      display_en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 29) == 0) mode_auto = ~mode_auto;
      step = ($urandom_range(0, 2) == 0);
      in_sa = $urandom;
      in_custom = $urandom;
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
